// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-master memory arbiter: address regions, write-enable codes, FSM states.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned WE_W     = 3;
  localparam int unsigned REGION_W = 4;

  // Region codes on addr[31:28]; IO covers 0x2 and 0x3, matched on addr[31:29].
  localparam logic [REGION_W-1:0] REGION_ROM = 4'h0;
  localparam logic [REGION_W-1:0] REGION_RAM = 4'h1;
  localparam logic [2:0]          REGION_IO  = 3'b001;

  localparam logic [WE_W-1:0] WE_NONE = 3'b000;
  localparam logic [WE_W-1:0] WE_WORD = 3'b001;
  localparam logic [WE_W-1:0] WE_HALF = 3'b010;
  localparam logic [WE_W-1:0] WE_BYTE = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_region_decode.sv
// Address-map decode on addr[31:28]; also reused by the memory's own enable decode.
module mem_region_decode
  import mem_arbiter_pkg::*;
(
  input  logic [REGION_W-1:0] region,
  input  logic [WE_W-1:0]     we,
  output logic                mapped,
  output logic                wprot_hit
);

  logic is_write;

  assign is_write  = |(we & (WE_WORD | WE_HALF | WE_BYTE));
  assign mapped    = (region == REGION_ROM) || (region == REGION_RAM) ||
                     (region[REGION_W-1:1] == REGION_IO);
  assign wprot_hit = (region == REGION_ROM) && is_write;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin two-master arbiter for the memory data port, fixed 2-cycle latency.
// Optional ROM write protection is enabled by defining MEM_ARB_WPROT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 m0_req,
  input  logic [ADDR_W-1:0]    m0_addr,
  input  logic [WE_W-1:0]      m0_we,
  input  logic [DATA_W-1:0]    m0_wdata,
  output logic                 m0_ack,
  output logic                 m0_err,
  output logic [DATA_W-1:0]    m0_rdata,
  input  logic                 m1_req,
  input  logic [ADDR_W-1:0]    m1_addr,
  input  logic [WE_W-1:0]      m1_we,
  input  logic [DATA_W-1:0]    m1_wdata,
  output logic                 m1_ack,
  output logic                 m1_err,
  output logic [DATA_W-1:0]    m1_rdata,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [WE_W-1:0]      mem_we,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [ERR_CNT_W-1:0] err_count
);

`ifdef MEM_ARB_WPROT_EN
  localparam logic WPROT_EN = 1'b1;
`else
  localparam logic WPROT_EN = 1'b0;
`endif

  arb_state_e          state;
  logic                grant;
  logic                last_grant;
  logic [ADDR_W-1:0]   sel_addr;
  logic [WE_W-1:0]     sel_we;
  logic [DATA_W-1:0]   sel_wdata;
  logic                mapped;
  logic                wprot_hit;
  logic                reject;

  mem_region_decode u_decode (
    .region    (sel_addr[ADDR_W-1:ADDR_W-REGION_W]),
    .we        (sel_we),
    .mapped    (mapped),
    .wprot_hit (wprot_hit)
  );

  assign reject = !mapped || (WPROT_EN && wprot_hit);

  // Memory port follows the granted master only while in ACCESS.
  always_comb begin
    sel_addr  = grant ? m1_addr  : m0_addr;
    sel_we    = grant ? m1_we    : m0_we;
    sel_wdata = grant ? m1_wdata : m0_wdata;
    mem_addr  = '0;
    mem_we    = WE_NONE;
    mem_wdata = '0;
    if (state == ST_ACCESS) begin
      mem_addr  = sel_addr;
      mem_we    = reject ? WE_NONE : sel_we;
      mem_wdata = sel_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      m0_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m0_rdata   <= '0;
      m1_ack     <= 1'b0;
      m1_err     <= 1'b0;
      m1_rdata   <= '0;
      err_count  <= '0;
    end else begin
      m0_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_ack <= 1'b0;
      m1_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            // On a tie the master that was not served last wins.
            grant <= (m0_req && m1_req) ? ~last_grant : m1_req;
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          last_grant <= grant;
          state      <= ST_ACK;
          if (grant) begin
            m1_ack   <= 1'b1;
            m1_err   <= reject;
            m1_rdata <= reject ? '0 : mem_rdata;
          end else begin
            m0_ack   <= 1'b1;
            m0_err   <= reject;
            m0_rdata <= reject ? '0 : mem_rdata;
          end
          if (reject && (err_count != {ERR_CNT_W{1'b1}})) begin
            err_count <= err_count + ERR_CNT_W'(1);
          end
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [2:0]  m0_we, m1_we;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_we;
  logic [7:0]  err_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ERR_CNT_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_count(err_count)
  );

  // Memory stub: 1024 words, word writes only, ROM region ignores writes, scrambled initial contents.
  function automatic logic [9:0] widx(input logic [31:0] a);
    return {a[29:28], a[9:2]};
  endfunction

  function automatic logic [31:0] pat(input logic [9:0] i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  logic [31:0] mem_arr [1024] = '{default: '0};
  logic [31:0] ref_mem [1024];

  assign mem_rdata = mem_arr[widx(mem_addr)] ^ pat(widx(mem_addr));

  always @(posedge clk) begin
    if (mem_we == 3'b001 && mem_addr[31:28] != 4'h0)
      mem_arr[widx(mem_addr)] <= mem_wdata ^ pat(widx(mem_addr));
  end

  // Transaction-level model state.
  int   exp_err_cnt;
  logic rr_last;

  function automatic logic model_reject(input logic [31:0] a, input logic [2:0] we);
    if (a[31:28] > 4'h3) return 1'b1;
`ifdef MEM_ARB_WPROT_EN
    if (a[31:28] == 4'h0 && we != 3'b000) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_we = '0; m1_we = '0; m0_wdata = '0; m1_wdata = '0;
    tick();
    tick();
    check("rst_ack0", 32'(m0_ack), 32'd0);
    check("rst_ack1", 32'(m1_ack), 32'd0);
    check("rst_err", 32'({m0_err, m1_err}), 32'd0);
    check("rst_rdata0", m0_rdata, 32'd0);
    check("rst_rdata1", m1_rdata, 32'd0);
    check("rst_errcnt", 32'(err_count), 32'd0);
    check("rst_mem", mem_addr | mem_wdata | 32'(mem_we), 32'd0);
    resetn = 1'b1;
    exp_err_cnt = 0;
    rr_last = 1'b1;
  endtask

  // Issue requests from the selected masters in one cycle; each drops its req after its ack.
  task automatic run_txns(input logic use0, input logic use1,
                          input logic [31:0] a0, input logic [2:0] w0, input logic [31:0] d0,
                          input logic [31:0] a1, input logic [2:0] w1, input logic [31:0] d1);
    int          order[$];
    int          m;
    logic [31:0] a, d, exp_rd, obs_rd;
    logic [2:0]  w;
    logic        rej, obs_ack, oth_ack, obs_err;
    if (use0 && use1) order = rr_last ? '{0, 1} : '{1, 0};
    else if (use0)    order = '{0};
    else              order = '{1};
    @(posedge clk);
    #1;
    m0_req = use0; m0_addr = a0; m0_we = w0; m0_wdata = d0;
    m1_req = use1; m1_addr = a1; m1_we = w1; m1_wdata = d1;
    for (int i = 0; i < order.size(); i++) begin
      m = order[i];
      a = (m == 0) ? a0 : a1;
      w = (m == 0) ? w0 : w1;
      d = (m == 0) ? d0 : d1;
      rej = model_reject(a, w);
      tick();
      check("access_addr", mem_addr, a);
      check("access_we", 32'(mem_we), rej ? 32'd0 : 32'(w));
      check("access_noack", 32'({m0_ack, m1_ack}), 32'd0);
      tick();
      exp_rd = rej ? 32'd0 : ref_mem[widx(a)];
      if (!rej && w == 3'b001 && a[31:28] != 4'h0) ref_mem[widx(a)] = d;
      if (rej && exp_err_cnt < 255) exp_err_cnt++;
      obs_ack = (m == 0) ? m0_ack : m1_ack;
      oth_ack = (m == 0) ? m1_ack : m0_ack;
      obs_err = (m == 0) ? m0_err : m1_err;
      obs_rd  = (m == 0) ? m0_rdata : m1_rdata;
      check("ack", 32'(obs_ack), 32'd1);
      check("other_ack", 32'(oth_ack), 32'd0);
      check("err", 32'(obs_err), 32'(rej));
      check("rdata", obs_rd, exp_rd);
      check("err_count", 32'(err_count), 32'(exp_err_cnt));
      check("ack_mem_idle", mem_addr | 32'(mem_we), 32'd0);
      if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
      rr_last = logic'(m);
      if (i < order.size() - 1) begin
        tick();
        check("gap_noack", 32'({m0_ack, m1_ack}), 32'd0);
      end
    end
  endtask

  function automatic logic [31:0] rand_addr(input int region);
    logic [31:0] a;
    a = $urandom;
    a[31:28] = 4'(region);
    a[9:2] = 8'($urandom_range(0, 7));
    return a;
  endfunction

  initial begin
    logic [31:0] a0, a1;
    logic [2:0]  w0, w1;
    logic [2:0]  we_tab [4];
    logic        u0, u1;
    int          sel;
    we_tab[0] = 3'b000; we_tab[1] = 3'b001; we_tab[2] = 3'b010; we_tab[3] = 3'b100;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(10'(i));

    // Single master write then read-back.
    do_reset();
    run_txns(1'b1, 1'b0, 32'h10000004, 3'b001, 32'hDEADBEEF, 32'h0, 3'b000, 32'h0);
    run_txns(1'b1, 1'b0, 32'h10000004, 3'b000, 32'h0, 32'h0, 3'b000, 32'h0);
    check("t1_readback", m0_rdata, 32'hDEADBEEF);
    check("t1_err", 32'(m0_err), 32'd0);

    // Both masters held: m0 wins the first tie after reset, then strict alternation.
    do_reset();
    @(posedge clk);
    #1;
    m0_req = 1'b1; m0_addr = 32'h10000100; m0_we = 3'b000;
    m1_req = 1'b1; m1_addr = 32'h20000200; m1_we = 3'b000;
    for (int k = 1; k <= 11; k++) begin
      tick();
      check("rr_ack0", 32'(m0_ack), (k == 2 || k == 8) ? 32'd1 : 32'd0);
      check("rr_ack1", 32'(m1_ack), (k == 5 || k == 11) ? 32'd1 : 32'd0);
    end
    check("rr_rdata0", m0_rdata, ref_mem[widx(32'h10000100)]);
    check("rr_rdata1", m1_rdata, ref_mem[widx(32'h20000200)]);
    m0_req = 1'b0; m1_req = 1'b0;
    rr_last = 1'b1;

    // Unmapped write from m1.
    run_txns(1'b0, 1'b1, 32'h0, 3'b000, 32'h0, 32'h50000000, 3'b001, 32'h12345678);
    check("t3_err_count", 32'(err_count), 32'd1);
    check("t3_rdata", m1_rdata, 32'd0);

    // Counter saturation.
    for (int i = 0; i < 300; i++) begin
      a0 = rand_addr($urandom_range(4, 15));
      w0 = we_tab[$urandom_range(0, 3)];
      if ($urandom_range(0, 1) == 0) run_txns(1'b1, 1'b0, a0, w0, $urandom, 32'h0, 3'b000, 32'h0);
      else                           run_txns(1'b0, 1'b1, 32'h0, 3'b000, 32'h0, a0, w0, $urandom);
    end
    check("t4_saturated", 32'(err_count), 32'd255);

    // Reset in the middle of an access.
    @(posedge clk);
    #1;
    m0_req = 1'b1; m0_addr = 32'h10000008; m0_we = 3'b000;
    tick();
    check("t5_in_access", mem_addr, 32'h10000008);
    resetn = 1'b0;
    m0_req = 1'b0;
    tick();
    check("t5_no_ack", 32'(m0_ack), 32'd0);
    check("t5_idle_mem", mem_addr, 32'd0);
    tick();
    check("t5_no_ack2", 32'(m0_ack), 32'd0);
    resetn = 1'b1;
    exp_err_cnt = 0;
    rr_last = 1'b1;
    run_txns(1'b1, 1'b0, 32'h10000008, 3'b000, 32'h0, 32'h0, 3'b000, 32'h0);

    // ROM write handling.
    run_txns(1'b1, 1'b0, 32'h00000010, 3'b001, 32'hCAFEF00D, 32'h0, 3'b000, 32'h0);
`ifdef MEM_ARB_WPROT_EN
    check("t6_rom_err", 32'(m0_err), 32'd1);
`else
    check("t6_rom_err", 32'(m0_err), 32'd0);
`endif
    run_txns(1'b0, 1'b1, 32'h0, 3'b000, 32'h0, 32'h00000010, 3'b000, 32'h0);
    check("t6_rom_unchanged", m1_rdata, pat(widx(32'h00000010)));

    // Randomized mixed traffic.
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(1, 3);
      u0 = (sel != 2);
      u1 = (sel != 1);
      a0 = rand_addr(($urandom_range(0, 9) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3));
      a1 = rand_addr(($urandom_range(0, 9) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3));
      w0 = we_tab[$urandom_range(0, 3)];
      w1 = we_tab[$urandom_range(0, 3)];
      run_txns(u0, u1, a0, w0, $urandom, a1, w1, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
